// File: rtl/animation_sequencer.sv
// Frame scheduler for the 7-segment animation engine: prescaled frame stepping,
// manual/auto animation selection, pause and single-step.
module animation_sequencer #(
  parameter int unsigned BASE_DIV      = 12_000_000,
  parameter int unsigned DIV_W         = 24,
  parameter int unsigned LOOPS_PER_ANI = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] ani_sel,
  input  logic       auto_mode,
  input  logic [2:0] speed,
  input  logic       pause,
  input  logic       step,
  input  logic [5:0] limit,
  output logic [5:0] ani_out,
  output logic [5:0] frame,
  output logic       frame_tick,
  output logic       loop_done
);

  localparam int unsigned LOOP_W = $clog2(LOOPS_PER_ANI + 1);
  localparam logic [DIV_W-1:0]  BASE     = DIV_W'(BASE_DIV);
  localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(LOOPS_PER_ANI);

  typedef enum logic [1:0] {RUN, PAUSE, SWITCH} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [LOOP_W-1:0] loop_cnt;
  logic              step_q;

  logic [DIV_W-1:0]  period;
  logic [DIV_W-1:0]  term;
  logic [5:0]        last;
  logic              at_term;
  logic              wrap_pt;
  logic              manual_req;
  logic              adv;
  logic              auto_sw;

  // Advance/switch decode for the current cycle
  always_comb begin
    period     = BASE >> speed;
    term       = (period == '0) ? '0 : period - DIV_W'(1);
    last       = (limit == 6'd0) ? 6'd0 : limit - 6'd1;
    at_term    = (div_cnt >= term);
    wrap_pt    = (frame >= last);
    manual_req = !auto_mode && (ani_sel != ani_out);
    adv        = 1'b0;
    case (state)
      RUN:     adv = !pause && at_term;
      PAUSE:   adv = step && !step_q;
      default: adv = 1'b0;
    endcase
    // Widened by one bit so loop_cnt+1 cannot overflow the counter width
    auto_sw = auto_mode && adv && wrap_pt &&
              (((LOOP_W+1)'(loop_cnt) + (LOOP_W+1)'(1)) >= (LOOP_W+1)'(LOOPS_PER_ANI));
  end

  // State, prescaler, frame counter and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ani_out    <= 6'd0;
      frame      <= 6'd0;
      frame_tick <= 1'b0;
      loop_done  <= 1'b0;
      div_cnt    <= '0;
      loop_cnt   <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q     <= step;
      frame_tick <= 1'b0;
      loop_done  <= 1'b0;
      if (manual_req) begin
        // Manual reselect wins over any advance in the same cycle
        ani_out  <= ani_sel;
        frame    <= 6'd0;
        div_cnt  <= '0;
        loop_cnt <= '0;
        state    <= SWITCH;
      end else begin
        case (state)
          RUN: begin
            if (pause)        state   <= PAUSE;
            else if (at_term) div_cnt <= '0;
            else              div_cnt <= div_cnt + DIV_W'(1);
          end
          PAUSE:   if (!pause) state <= RUN;
          SWITCH:  state <= pause ? PAUSE : RUN;
          default: state <= RUN;
        endcase
        if (adv) begin
          frame_tick <= 1'b1;
          if (wrap_pt) begin
            frame     <= 6'd0;
            loop_done <= 1'b1;
            if (auto_sw) begin
              ani_out  <= ani_out + 6'd1;
              div_cnt  <= '0;
              loop_cnt <= '0;
              state    <= SWITCH;
            end else if (loop_cnt < LOOP_MAX) begin
              loop_cnt <= loop_cnt + LOOP_W'(1);
            end
          end else begin
            frame <= frame + 6'd1;
          end
        end
      end
    end
  end

endmodule
